lif_sweep_scheduler: RTL
========================

# lif_sweep_scheduler

Time-multiplexed scheduler for a bank of leaky integrate-and-fire neurons sharing one update datapath. It buffers input currents from upstream requesters and, on each timestep tick, sweeps every neuron once through the shared leak/integrate/fire evaluation. Spikes are emitted as indexed events on a valid/ready stream. It sits between the stimulus/input fabric and the downstream spike consumer.

## Interface
- N_NEURONS, 8, number of neurons in the sweep (≥2)
- W, 8, membrane/current/threshold width
- LEAK_SHIFT, 1, leak as right-shift of membrane per timestep
- THRESH_RESET, 127, threshold loaded into every neuron at reset
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  start one timestep sweep (single-cycle pulse)
- cur_valid  in  1  input current write request
- cur_ready  out  1  always 1 (accepts one write per cycle)
- cur_idx  in  IDX_W  target neuron, IDX_W = $clog2(N_NEURONS)
- cur_val  in  W  current added to target's accumulator
- cfg_we  in  1  threshold write strobe
- cfg_idx  in  IDX_W  neuron whose threshold is written
- cfg_thresh  in  W  new threshold
- spk_valid  out  1  spike event pending
- spk_ready  in  1  consumer accepts event
- spk_idx  out  IDX_W  index of spiking neuron
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep finished
- overrun  out  1  one-cycle pulse, tick arrived while busy

## Operation
- Per-neuron storage: membrane mem[i], input accumulator acc[i], threshold thr[i], all W bits.
- Current write: acc[cur_idx] <= sat(acc[cur_idx] + cur_val); saturates at 2^W-1.
- FSM: IDLE, SWEEP. IDLE + tick → SWEEP, ptr=0. SWEEP evaluates neuron ptr each non-stalled cycle; after ptr=N_NEURONS-1 evaluates → IDLE with done.
- Evaluation of neuron p: nxt = sat(acc[p] + (mem[p] >> LEAK_SHIFT)), computed in W+1 bits then clamped. fire = (nxt ≥ thr[p]). mem[p] <= fire ? 0 : nxt. acc[p] <= 0.
- Fire loads output register: spk_valid<=1, spk_idx<=p. Register clears on spk_valid&spk_ready unless reloaded the same cycle.
- Stall: if fire and spk_valid=1 and spk_ready=0, neuron p is not evaluated (mem, acc, ptr unchanged); retried next cycle.
- Current write to neuron p in the same cycle p is evaluated: acc[p] <= sat(cur_val) (the write belongs to the next timestep; evaluated value uses old acc). Writes to not-yet-evaluated neurons count in this sweep.
- Threshold write: thr[cfg_idx] <= cfg_thresh immediately; same-cycle evaluation of that neuron uses old threshold.
- tick while busy: ignored, overrun pulses; sweep unaffected.
- Reset (including mid-sweep): mem=0, acc=0, thr=THRESH_RESET, FSM=IDLE, ptr=0, spk_valid=0, spk_idx=0, busy=0, done=0, overrun=0. Pending spike is discarded.

## Timing
- tick in cycle t → busy=1 from t+1; neuron 0 evaluated in t+1.
- No stalls: neuron k evaluated in t+1+k; its spike visible on spk_valid at t+2+k.
- done=1 and busy=0 in cycle t+1+N_NEURONS; each stall cycle delays this by one.
- tick in the done cycle is accepted (FSM is IDLE).
- spk_valid, once high, holds spk_idx stable until accepted.
- Zero-latency current write: visible to an evaluation in the next cycle.

## Structure
- Shared package lif_pkg: state enum {IDLE, SWEEP}, sat_add function (W-parameterised), IDX_W derivation.
- Sub-module lif_neuron_update: combinational nxt/fire from (acc, mem, thr); reused by any future multi-lane scheduler.
- Storage as flop arrays; no RAM macro.

## Test plan
- Defaults: write cur 100 to neuron 3, tick → mem[3]=100, no spike; write 80, tick → nxt=80+50=130 ≥127, spk_idx=3, mem[3]=0; done at t+9.
- Saturation: two writes of 200 to neuron 0, tick → acc=255, nxt=255, spike idx 0.
- Backpressure: neurons 0 and 1 loaded with 127, spk_ready=0 for 5 cycles → sweep stalls at neuron 1; done delayed 5 cycles; events 0 then 1 in order, none lost.
- Overrun/same-cycle: tick during busy → overrun pulse, single done; cur write to neuron 2 in its evaluation cycle → appears only in next sweep.
- Threshold: set thr[5]=10, write 12 → spike; set thr[5]=255, write 254 → no spike, mem=254.
- Reset at neuron 4 with spk_valid=1 → next cycle all outputs 0, thr=127, fresh tick sweeps from neuron 0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF sweep scheduler: FSM state encoding,
// index-width derivation and a width-parameterised saturating adder.
package lif_pkg;

    localparam int SAT_MAXW = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands must already fit in w bits; the result is clamped to 2^w-1.
    function automatic logic [SAT_MAXW-1:0] sat_add(input logic [SAT_MAXW-1:0] a,
                                                    input logic [SAT_MAXW-1:0] b,
                                                    input int                  w);
        logic [SAT_MAXW:0] sum;
        logic [SAT_MAXW:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ~({(SAT_MAXW+1){1'b1}} << w);
        return (sum > lim) ? lim[SAT_MAXW-1:0] : sum[SAT_MAXW-1:0];
    endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational leak/integrate/fire evaluation of one neuron; shared by the
// sweep scheduler and reusable by wider multi-lane variants.
module lif_neuron_update
    import lif_pkg::*;
#(
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] mem_i,
    input  logic [W-1:0] thr_i,
    output logic [W-1:0] nxt_o,
    output logic         fire_o
);

    logic [SAT_MAXW-1:0] sum;

    // The clamp keeps sum below 2^W, so comparing the full word equals comparing nxt.
    always_comb begin
        sum    = sat_add(SAT_MAXW'(acc_i), SAT_MAXW'(mem_i >> LEAK_SHIFT), W);
        nxt_o  = sum[W-1:0];
        fire_o = (sum >= SAT_MAXW'(thr_i));
    end

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed LIF scheduler: buffers input currents per neuron and, on each
// tick, sweeps all neurons through one shared update datapath, emitting spike events.
module lif_sweep_scheduler
    import lif_pkg::*;
#(
    parameter  int N_NEURONS    = 8,
    parameter  int W            = 8,
    parameter  int LEAK_SHIFT   = 1,
    parameter  int THRESH_RESET = 127,
    localparam int IDX_W        = idx_w(N_NEURONS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             cur_valid_i,
    output logic             cur_ready_o,
    input  logic [IDX_W-1:0] cur_idx_i,
    input  logic [W-1:0]     cur_val_i,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_idx_i,
    input  logic [W-1:0]     cfg_thresh_i,
    output logic             spk_valid_o,
    input  logic             spk_ready_i,
    output logic [IDX_W-1:0] spk_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             spk_valid_q;
    logic [IDX_W-1:0] spk_idx_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    logic [W-1:0] mem_q [N_NEURONS];
    logic [W-1:0] acc_q [N_NEURONS];
    logic [W-1:0] thr_q [N_NEURONS];
    logic [W-1:0] mem_d [N_NEURONS];
    logic [W-1:0] acc_d [N_NEURONS];
    logic [W-1:0] thr_d [N_NEURONS];

    logic [W-1:0] nxt;
    logic         fire;
    logic         in_sweep;
    logic         stall;
    logic         eval;
    logic [W:0]   cur_sum;
    logic [W-1:0] cur_sat;

    lif_neuron_update #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_upd (
        .acc_i  (acc_q[ptr_q]),
        .mem_i  (mem_q[ptr_q]),
        .thr_i  (thr_q[ptr_q]),
        .nxt_o  (nxt),
        .fire_o (fire)
    );

    // A firing neuron can only be committed if the output register is free or draining now.
    always_comb begin
        in_sweep = (state_q == SWEEP);
        stall    = in_sweep && fire && spk_valid_q && !spk_ready_i;
        eval     = in_sweep && !stall;
        cur_sum  = {1'b0, acc_q[cur_idx_i]} + {1'b0, cur_val_i};
        cur_sat  = cur_sum[W] ? {W{1'b1}} : cur_sum[W-1:0];
    end

    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            mem_d[i] = mem_q[i];
            acc_d[i] = acc_q[i];
            thr_d[i] = thr_q[i];
            if (eval && (ptr_q == IDX_W'(i))) begin
                mem_d[i] = fire ? '0 : nxt;
                // A write landing on the neuron being evaluated seeds the next timestep.
                acc_d[i] = (cur_valid_i && (cur_idx_i == IDX_W'(i))) ? cur_val_i : '0;
            end else if (cur_valid_i && (cur_idx_i == IDX_W'(i))) begin
                acc_d[i] = cur_sat;
            end
            if (cfg_we_i && (cfg_idx_i == IDX_W'(i))) begin
                thr_d[i] = cfg_thresh_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
                acc_q[i] <= '0;
                thr_q[i] <= W'(THRESH_RESET);
            end
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= mem_d[i];
                acc_q[i] <= acc_d[i];
                thr_q[i] <= thr_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_i) begin
                        state_q <= SWEEP;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (tick_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (eval) begin
                        if (ptr_q == LAST_IDX) begin
                            state_q <= IDLE;
                            ptr_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (eval && fire) begin
                spk_valid_q <= 1'b1;
                spk_idx_q   <= ptr_q;
            end else if (spk_valid_q && spk_ready_i) begin
                spk_valid_q <= 1'b0;
            end
        end
    end

    assign cur_ready_o = 1'b1;
    assign spk_valid_o = spk_valid_q;
    assign spk_idx_o   = spk_idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;

endmodule
